wb_unit: RTL and testbench

Writeback stage that sits directly upstream of the register file and is its only write port driver. Accepts retiring instructions from the execute stage over a valid/ready handshake, waits for load data from the data-memory port where needed, sign/zero-extends and byte-aligns load data, and drives one registered write per instruction. It suppresses writes to x0 and publishes the pending destination register for hazard detection in decode.

---
 rtl/wb_unit_if.sv | 37 +++
 rtl/wb_unit.sv | 173 +++++++++++++++++
 tb/tb_wb_unit.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_unit_if.sv
// wb_unit_if -- bundle of every signal between the writeback unit and its
// neighbours (execute stage, data-memory read port, register file, decode).
//   master : execute/memory/register-file side (drives in_* and mem_*).
//   slave  : the writeback unit (drives in_ready, rf_*, pend_*, err).
// Parameters: ADDR_WIDTH (register index width), DATA_WIDTH (data width).
interface wb_unit_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_rd;
  logic                  in_is_load;
  logic [2:0]            in_funct3;
  logic [1:0]            in_addr_lo;
  logic [DATA_WIDTH-1:0] in_result;
  logic                  mem_rvalid;
  logic [31:0]           mem_rdata;
  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic                  pend_valid;
  logic [ADDR_WIDTH-1:0] pend_rd;
  logic                  err;

  modport master (
    output in_valid, in_rd, in_is_load, in_funct3, in_addr_lo, in_result,
           mem_rvalid, mem_rdata,
    input  in_ready, rf_wen, rf_waddr, rf_wdata, pend_valid, pend_rd, err
  );

  modport slave (
    input  in_valid, in_rd, in_is_load, in_funct3, in_addr_lo, in_result,
           mem_rvalid, mem_rdata,
    output in_ready, rf_wen, rf_waddr, rf_wdata, pend_valid, pend_rd, err
  );
endinterface

// File: rtl/wb_unit.sv
// wb_unit -- writeback stage, sole write-port driver of the register file.
// Accepts retiring instructions over in_valid/in_ready, waits for load data
// on mem_rvalid, extends/aligns it, and issues one registered write per
// instruction (suppressed for x0). Publishes the pending rd for decode.
// Ports: clk, rst (synchronous, active-high), bus (wb_unit_if.slave).
// Optional feature: define WB_TIMEOUT_EN to abandon a load after 255 idle
// cycles in WAIT_MEM and raise the sticky err flag; otherwise err is 0.
module wb_unit #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  wb_unit_if.slave   bus
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_MEM = 2'd1;
  localparam logic [1:0] WRITE    = 2'd2;

  // Byte selected by addr_lo, half selected by addr_lo[1].
  function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                              input logic [1:0]  alo,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (alo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      2'd3:    b = w[31:24];
      default: b = w[7:0];
    endcase
    h = alo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  logic [1:0]            state_r, state_s;
  logic [ADDR_WIDTH-1:0] rd_r, rd_s;
  logic [2:0]            f3_r;
  logic [1:0]            alo_r;
  logic                  rf_wen_r;
  logic [ADDR_WIDTH-1:0] rf_waddr_r;
  logic [DATA_WIDTH-1:0] rf_wdata_r;
  logic                  pend_valid_r, pend_valid_s;
  logic                  in_ready_s;
  logic                  take_s;
  logic                  mem_take_s;
  logic                  timeout_s;

  assign in_ready_s = (state_r != WAIT_MEM);
  assign take_s     = bus.in_valid && in_ready_s;
  // Load data is only taken while waiting; stray pulses elsewhere are dropped.
  assign mem_take_s = (state_r == WAIT_MEM) && bus.mem_rvalid;

  // Next-state and next pending-destination decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE, WRITE: begin
        if (take_s) begin
          state_s = bus.in_is_load ? WAIT_MEM : WRITE;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT_MEM: begin
        if (bus.mem_rvalid) begin
          state_s = WRITE;
        end else if (timeout_s) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT_MEM;
        end
      end
      default: state_s = IDLE;
    endcase

    if (take_s) begin
      rd_s = bus.in_rd;
    end else begin
      rd_s = rd_r;
    end

    if (((state_s == WAIT_MEM) || (state_s == WRITE)) && (rd_s != {ADDR_WIDTH{1'b0}})) begin
      pend_valid_s = 1'b1;
    end else begin
      pend_valid_s = 1'b0;
    end
  end

  // State, captured instruction fields and registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      rd_r         <= {ADDR_WIDTH{1'b0}};
      f3_r         <= 3'd0;
      alo_r        <= 2'd0;
      rf_wen_r     <= 1'b0;
      rf_waddr_r   <= {ADDR_WIDTH{1'b0}};
      rf_wdata_r   <= {DATA_WIDTH{1'b0}};
      pend_valid_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      pend_valid_r <= pend_valid_s;
      if (take_s) begin
        rd_r  <= bus.in_rd;
        f3_r  <= bus.in_funct3;
        alo_r <= bus.in_addr_lo;
      end
      // rf_wdata doubles as the result register, so a WRITE cycle is just
      // the cycle after it was loaded.
      if (take_s && !bus.in_is_load) begin
        rf_wen_r   <= (bus.in_rd != {ADDR_WIDTH{1'b0}});
        rf_waddr_r <= bus.in_rd;
        rf_wdata_r <= bus.in_result;
      end else if (mem_take_s) begin
        rf_wen_r   <= (rd_r != {ADDR_WIDTH{1'b0}});
        rf_waddr_r <= rd_r;
        rf_wdata_r <= DATA_WIDTH'(load_extend(f3_r, alo_r, bus.mem_rdata));
      end else begin
        rf_wen_r   <= 1'b0;
      end
    end
  end

`ifdef WB_TIMEOUT_EN
  logic [7:0] to_cnt_r;
  logic       err_r;

  assign timeout_s = (state_r == WAIT_MEM) && !bus.mem_rvalid && (to_cnt_r == 8'd255);

  // Load-timeout counter and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_r <= 8'd0;
      err_r    <= 1'b0;
    end else begin
      if (take_s && bus.in_is_load) begin
        to_cnt_r <= 8'd0;
      end else if (state_r == WAIT_MEM) begin
        to_cnt_r <= to_cnt_r + 8'd1;
      end else begin
        to_cnt_r <= to_cnt_r;
      end
      if (timeout_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign bus.err = err_r;
`else
  assign timeout_s = 1'b0;
  assign bus.err   = 1'b0;
`endif

  assign bus.in_ready   = in_ready_s;
  assign bus.rf_wen     = rf_wen_r;
  assign bus.rf_waddr   = rf_waddr_r;
  assign bus.rf_wdata   = rf_wdata_r;
  assign bus.pend_valid = pend_valid_r;
  assign bus.pend_rd    = rd_r;

endmodule

// File: tb/tb_wb_unit.sv
// tb_wb_unit -- self-checking bench for wb_unit: reset values, a per-cycle
// vector table (back-to-back writes, LB/LHU/LH extension, stray load data,
// x0), reset during a load, randomized traffic against a transaction-level
// model, and the load-timeout behaviour for the current build.
module tb_wb_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  wb_unit_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

  wb_unit #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        v;
    logic [4:0]  rd;
    logic        ld;
    logic [2:0]  f3;
    logic [1:0]  alo;
    logic [31:0] res;
    logic        rv;
    logic [31:0] rdat;
    logic        e_wen;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_rdy;
    logic        e_pv;
    logic [4:0]  e_prd;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic ld,
                       input logic [2:0] f3, input logic [1:0] alo,
                       input logic [31:0] res, input logic rv, input logic [31:0] rdat);
    bus.in_valid   = v;
    bus.in_rd      = rd;
    bus.in_is_load = ld;
    bus.in_funct3  = f3;
    bus.in_addr_lo = alo;
    bus.in_result  = res;
    bus.mem_rvalid = rv;
    bus.mem_rdata  = rdat;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 3'd0, 2'd0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference load extension from plain arithmetic on the selected field.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] alo,
                                           input logic [31:0] w);
    int b;
    int h;
    b = int'((w >> (8 * int'(alo))) % 32'd256);
    h = int'((w >> (16 * int'(alo[1]))) % 32'd65536);
    case (f3)
      3'b000: begin if (b > 127) b = b - 256; return 32'(b); end
      3'b001: begin if (h > 32767) h = h - 65536; return 32'(h); end
      3'b100: return 32'(b);
      3'b101: return 32'(h);
      default: return w;
    endcase
  endfunction

  logic        m_wait;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  logic [1:0]  m_alo;
  int          m_wcnt;
  logic        m_wr;
  logic [31:0] m_data;
  logic        saw_wen;

  initial begin
    idle();
    // Fields: v rd ld f3 alo res rv rdat | wen addr data rdy pv prd
    tbl[0]  = '{1'b1, 5'd1, 1'b0, 3'd0, 2'd0, 32'h11111111, 1'b0, 32'h0,        1'b1, 5'd1, 32'h11111111, 1'b1, 1'b1, 5'd1};
    tbl[1]  = '{1'b1, 5'd2, 1'b0, 3'd0, 2'd0, 32'h22222222, 1'b0, 32'h0,        1'b1, 5'd2, 32'h22222222, 1'b1, 1'b1, 5'd2};
    tbl[2]  = '{1'b1, 5'd0, 1'b0, 3'd0, 2'd0, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd0};
    tbl[3]  = '{1'b0, 5'd0, 1'b0, 3'd0, 2'd0, 32'h0,        1'b0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd0};
    tbl[4]  = '{1'b1, 5'd5, 1'b1, 3'b000, 2'd3, 32'h0,      1'b1, 32'h12345678, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 5'd5};
    tbl[5]  = '{1'b1, 5'd9, 1'b0, 3'd0, 2'd0, 32'hCAFEF00D, 1'b0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 5'd5};
    tbl[6]  = '{1'b0, 5'd0, 1'b0, 3'd0, 2'd0, 32'h0,        1'b0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 5'd5};
    tbl[7]  = '{1'b0, 5'd0, 1'b0, 3'd0, 2'd0, 32'h0,        1'b1, 32'h80FF7F01, 1'b1, 5'd5, 32'hFFFFFF80, 1'b1, 1'b1, 5'd5};
    tbl[8]  = '{1'b0, 5'd0, 1'b0, 3'd0, 2'd0, 32'h0,        1'b0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd0};
    tbl[9]  = '{1'b0, 5'd0, 1'b0, 3'd0, 2'd0, 32'h0,        1'b1, 32'h80FF7F01, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd0};
    tbl[10] = '{1'b1, 5'd7, 1'b1, 3'b101, 2'd2, 32'h0,      1'b0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 5'd7};
    tbl[11] = '{1'b0, 5'd0, 1'b0, 3'd0, 2'd0, 32'h0,        1'b1, 32'h80FF7F01, 1'b1, 5'd7, 32'h000080FF, 1'b1, 1'b1, 5'd7};
    tbl[12] = '{1'b0, 5'd0, 1'b0, 3'd0, 2'd0, 32'h0,        1'b0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd0};
    tbl[13] = '{1'b1, 5'd6, 1'b1, 3'b001, 2'd0, 32'h0,      1'b0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 5'd6};
    tbl[14] = '{1'b0, 5'd0, 1'b0, 3'd0, 2'd0, 32'h0,        1'b1, 32'h00008001, 1'b1, 5'd6, 32'hFFFF8001, 1'b1, 1'b1, 5'd6};
    tbl[15] = '{1'b1, 5'd0, 1'b1, 3'b010, 2'd0, 32'h0,      1'b0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 5'd0};
    tbl[16] = '{1'b0, 5'd0, 1'b0, 3'd0, 2'd0, 32'h0,        1'b1, 32'hA5A5A5A5, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd0};
    tbl[17] = '{1'b0, 5'd0, 1'b0, 3'd0, 2'd0, 32'h0,        1'b0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd0};

    // Reset held two cycles
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_wen",   32'(bus.rf_wen),     32'd0);
    chk("rst_waddr", 32'(bus.rf_waddr),   32'd0);
    chk("rst_wdata", bus.rf_wdata,        32'd0);
    chk("rst_pv",    32'(bus.pend_valid), 32'd0);
    chk("rst_prd",   32'(bus.pend_rd),    32'd0);
    chk("rst_err",   32'(bus.err),        32'd0);
    chk("rst_rdy",   32'(bus.in_ready),   32'd1);
    tick();
    chk("rst_rdy1",  32'(bus.in_ready),   32'd1);
    chk("rst_wen1",  32'(bus.rf_wen),     32'd0);

    // Table-driven per-cycle vectors
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].v, tbl[i].rd, tbl[i].ld, tbl[i].f3, tbl[i].alo, tbl[i].res, tbl[i].rv, tbl[i].rdat);
      tick();
      chk($sformatf("tbl%0d_wen", i), 32'(bus.rf_wen),     32'(tbl[i].e_wen));
      chk($sformatf("tbl%0d_rdy", i), 32'(bus.in_ready),   32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_pv",  i), 32'(bus.pend_valid), 32'(tbl[i].e_pv));
      chk($sformatf("tbl%0d_err", i), 32'(bus.err),        32'd0);
      if (tbl[i].e_wen) begin
        chk($sformatf("tbl%0d_waddr", i), 32'(bus.rf_waddr), 32'(tbl[i].e_addr));
        chk($sformatf("tbl%0d_wdata", i), bus.rf_wdata,      tbl[i].e_data);
      end
      if (tbl[i].e_pv) begin
        chk($sformatf("tbl%0d_prd", i), 32'(bus.pend_rd), 32'(tbl[i].e_prd));
      end
    end

    // Reset while a load is outstanding, then late load data
    drive(1'b1, 5'd3, 1'b1, 3'b010, 2'd0, 32'h0, 1'b0, 32'h0);
    tick();
    chk("ml_rdy", 32'(bus.in_ready),   32'd0);
    chk("ml_pv",  32'(bus.pend_valid), 32'd1);
    idle();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ml_rst_rdy", 32'(bus.in_ready),   32'd1);
    chk("ml_rst_pv",  32'(bus.pend_valid), 32'd0);
    drive(1'b0, 5'd0, 1'b0, 3'd0, 2'd0, 32'h0, 1'b1, 32'h55555555);
    tick();
    chk("ml_late_wen", 32'(bus.rf_wen),     32'd0);
    chk("ml_late_rdy", 32'(bus.in_ready),   32'd1);
    chk("ml_late_pv",  32'(bus.pend_valid), 32'd0);
    idle();
    tick();
    chk("ml_idle_wen", 32'(bus.rf_wen), 32'd0);

    // Randomized traffic against a transaction-level model
    m_wait = 1'b0;
    m_rd   = 5'd0;
    m_f3   = 3'd0;
    m_alo  = 2'd0;
    m_wcnt = 0;
    for (int c = 0; c < 400; c++) begin
      logic        v, ld, rv;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [1:0]  alo;
      logic [31:0] res, rdat;
      v    = ($urandom_range(0, 9) < 6);
      ld   = ($urandom_range(0, 9) < 4);
      rv   = ($urandom_range(0, 9) < 3);
      rd   = 5'($urandom_range(0, 7));
      f3   = 3'($urandom_range(0, 7));
      alo  = 2'($urandom_range(0, 3));
      res  = $urandom;
      rdat = $urandom;
      if (m_wait && m_wcnt >= 20) rv = 1'b1;
      drive(v, rd, ld, f3, alo, res, rv, rdat);
      m_wr = 1'b0;
      m_data = 32'd0;
      if (m_wait) begin
        if (rv) begin
          m_wr   = 1'b1;
          m_data = ref_load(m_f3, m_alo, rdat);
          m_wait = 1'b0;
        end else begin
          m_wcnt++;
        end
      end else if (v) begin
        m_rd  = rd;
        m_f3  = f3;
        m_alo = alo;
        if (ld) begin
          m_wait = 1'b1;
          m_wcnt = 0;
        end else begin
          m_wr   = 1'b1;
          m_data = res;
        end
      end
      tick();
      chk("rnd_wen", 32'(bus.rf_wen), 32'(m_wr && (m_rd != 5'd0)));
      chk("rnd_rdy", 32'(bus.in_ready), 32'(!m_wait));
      chk("rnd_pv",  32'(bus.pend_valid), 32'((m_wait || m_wr) && (m_rd != 5'd0)));
      if (m_wr && (m_rd != 5'd0)) begin
        chk("rnd_waddr", 32'(bus.rf_waddr), 32'(m_rd));
        chk("rnd_wdata", bus.rf_wdata, m_data);
      end
      if ((m_wait || m_wr) && (m_rd != 5'd0)) begin
        chk("rnd_prd", 32'(bus.pend_rd), 32'(m_rd));
      end
    end

    // Load that never receives data
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b1, 5'd4, 1'b1, 3'b010, 2'd0, 32'h0, 1'b0, 32'h0);
    tick();
    idle();
    saw_wen = 1'b0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (bus.rf_wen) saw_wen = 1'b1;
    end
    chk("to_no_write", 32'(saw_wen), 32'd0);
`ifdef WB_TIMEOUT_EN
    chk("to_err", 32'(bus.err),        32'd1);
    chk("to_rdy", 32'(bus.in_ready),   32'd1);
    chk("to_pv",  32'(bus.pend_valid), 32'd0);
`else
    chk("to_err", 32'(bus.err),        32'd0);
    chk("to_rdy", 32'(bus.in_ready),   32'd0);
    chk("to_pv",  32'(bus.pend_valid), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
